packet_injector: RTL and testbench

//  Network-interface source stage. Turns a packet request from the local processing element into a flit stream.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/inj_fifo.sv | 61 ++++++
 rtl/packet_injector.sv | 137 +++++++++++++
 tb/tb_packet_injector.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC constants, injector state encoding and the head-flit builder.
// Flit layout: head = {tail,1,dst_x,dst_y,src_x,src_y,len}, body = {tail,0,payload}.
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int PAYLOAD_W = 14;
  localparam int COORD_W   = 2;
  localparam int HDR_LEN_W = 6;
  localparam int TAIL_BIT  = 15;
  localparam int HEAD_BIT  = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } inj_state_e;

  // A head-only packet (len == 0) carries the tail bit on the head flit itself.
  function automatic logic [FLIT_W-1:0] build_head(
    input logic [COORD_W-1:0]   dst_x,
    input logic [COORD_W-1:0]   dst_y,
    input logic [COORD_W-1:0]   src_x,
    input logic [COORD_W-1:0]   src_y,
    input logic [HDR_LEN_W-1:0] len
  );
    return {(len == '0), 1'b1, dst_x, dst_y, src_x, src_y, len};
  endfunction

endpackage

// File: rtl/inj_fifo.sv
// Synchronous first-word-fall-through payload FIFO for the packet injector.
// Writes while full are dropped, even if a read happens in the same cycle.
module inj_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/packet_injector.sv
// NoC source stage: turns a packet request into head/body flits toward the router.
// Define NOC_INJ_STATS_EN to add the flit_count/pkt_count statistics outputs.
module packet_injector
  import noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   X,
  input  logic [COORD_W-1:0]   Y,
  input  logic                 turnoff,
  input  logic                 pkt_start,
  input  logic [COORD_W-1:0]   pkt_dst_x,
  input  logic [COORD_W-1:0]   pkt_dst_y,
  input  logic [LEN_W-1:0]     pkt_len,
  output logic                 pkt_ready,
  input  logic                 wr_en,
  input  logic [PAYLOAD_W-1:0] wr_data,
  output logic                 fifo_full,
  output logic                 send,
  output logic [FLIT_W-1:0]    flit,
  input  logic                 hand_shake,
  output logic                 busy
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [15:0]          flit_count,
  output logic [7:0]           pkt_count
`endif
);

  inj_state_e           state_q, state_d;
  logic [FLIT_W-1:0]    head_q, head_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q;
  logic                 fifo_empty, fifo_pop;
  logic [PAYLOAD_W-1:0] fifo_rd_data;
  logic [FLIT_W-1:0]    body_flit;
  logic                 send_c;
  logic [FLIT_W-1:0]    flit_c;

  inj_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  // ready_q holds pkt_ready low for the first cycle after reset release.
  assign pkt_ready = ready_q && (state_q == IDLE) && !turnoff;
  assign busy      = (state_q != IDLE);
  assign send      = send_c;
  assign flit      = flit_c;

  always_comb begin
    body_flit                  = '0;
    body_flit[TAIL_BIT]        = (cnt_q == LEN_W'(1));
    body_flit[HEAD_BIT]        = 1'b0;
    body_flit[PAYLOAD_W-1:0]   = fifo_rd_data;
  end

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    cnt_d    = cnt_q;
    send_c   = 1'b0;
    flit_c   = head_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_start && pkt_ready) begin
          head_d  = build_head(pkt_dst_x, pkt_dst_y, X, Y, pkt_len);
          cnt_d   = pkt_len;
          state_d = HEAD;
        end
      end
      HEAD: begin
        send_c = 1'b1;
        if (hand_shake) state_d = (cnt_q == '0) ? IDLE : BODY;
      end
      BODY: begin
        // The FIFO head word is shown directly; an empty FIFO simply stalls.
        flit_c = body_flit;
        send_c = !fifo_empty;
        if (send_c && hand_shake) begin
          fifo_pop = 1'b1;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end

`ifdef NOC_INJ_STATS_EN
  logic [15:0] flit_count_q;
  logic [7:0]  pkt_count_q;
  logic        accept;

  assign accept     = send_c && hand_shake;
  assign flit_count = flit_count_q;
  assign pkt_count  = pkt_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_count_q <= '0;
      pkt_count_q  <= '0;
    end else if (accept) begin
      flit_count_q <= flit_count_q + 1'b1;
      if (flit_c[TAIL_BIT]) pkt_count_q <= pkt_count_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector: expected flits are queued at stimulus time
// and compared when the router side accepts them.
module tb_packet_injector;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  X, Y;
  logic        turnoff;
  logic        pkt_start;
  logic [1:0]  pkt_dst_x, pkt_dst_y;
  logic [5:0]  pkt_len;
  logic        pkt_ready;
  logic        wr_en;
  logic [13:0] wr_data;
  logic        fifo_full;
  logic        send;
  logic [15:0] flit;
  logic        hand_shake;
  logic        busy;
`ifdef NOC_INJ_STATS_EN
  logic [15:0] flit_count;
  logic [7:0]  pkt_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_flit;

  packet_injector dut (
    .clk        (clk),
    .reset      (reset),
    .X          (X),
    .Y          (Y),
    .turnoff    (turnoff),
    .pkt_start  (pkt_start),
    .pkt_dst_x  (pkt_dst_x),
    .pkt_dst_y  (pkt_dst_y),
    .pkt_len    (pkt_len),
    .pkt_ready  (pkt_ready),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .send       (send),
    .flit       (flit),
    .hand_shake (hand_shake),
    .busy       (busy)
`ifdef NOC_INJ_STATS_EN
    ,
    .flit_count (flit_count),
    .pkt_count  (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] head_of(input logic [1:0] dx, input logic [1:0] dy,
                                          input logic [5:0] len);
    return {(len == 6'd0), 1'b1, dx, dy, X, Y, len};
  endfunction

  function automatic logic [15:0] body_of(input logic tail, input logic [13:0] payload);
    return {tail, 1'b0, payload};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [13:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic start_pkt(input logic [1:0] dx, input logic [1:0] dy, input logic [5:0] len);
    pkt_start = 1'b1;
    pkt_dst_x = dx;
    pkt_dst_y = dy;
    pkt_len   = len;
    tick();
    pkt_start = 1'b0;
  endtask

  // Scoreboard side: every accepted flit must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && send === 1'b1 && hand_shake === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_flit observed=%h expected=none", flit);
      end
      if (exp_q.size() != 0) begin
        exp_flit = exp_q.pop_front();
        chk("flit", {16'h0, flit}, {16'h0, exp_flit});
        $display("flit accepted %h (expected %h) t=%0t", flit, exp_flit, $time);
      end
    end
  end

  initial begin
    reset = 1'b1; X = 2'd2; Y = 2'd0; turnoff = 1'b0; pkt_start = 1'b0;
    pkt_dst_x = '0; pkt_dst_y = '0; pkt_len = '0; wr_en = 1'b0; wr_data = '0;
    hand_shake = 1'b0;
    #1;
    chk("rst_send", send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flit", flit, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ready", pkt_ready, 0);
    tick(); tick();
    reset = 1'b0;
    chk("ready_at_release", pkt_ready, 0);
    tick();
    chk("ready_after_release", pkt_ready, 1);

    // Head-only packet
    hand_shake = 1'b1;
    exp_q.push_back(head_of(2'd3, 2'd0, 6'd0));
    start_pkt(2'd3, 2'd0, 6'd0);
    chk("ho_send", send, 1);
    chk("ho_flit", flit, head_of(2'd3, 2'd0, 6'd0));
    chk("ho_busy", busy, 1);
    chk("ho_ready_busy", pkt_ready, 0);
    tick();
    chk("ho_busy_after", busy, 0);
    chk("ho_send_after", send, 0);
`ifdef NOC_INJ_STATS_EN
    chk("ho_flit_count", flit_count, 1);
    chk("ho_pkt_count", pkt_count, 1);
`endif

    // Three-body packet, one flit per cycle
    push_word(14'h1); push_word(14'h2); push_word(14'h3);
    exp_q.push_back(head_of(2'd1, 2'd1, 6'd3));
    exp_q.push_back(body_of(1'b0, 14'h1));
    exp_q.push_back(body_of(1'b0, 14'h2));
    exp_q.push_back(body_of(1'b1, 14'h3));
    start_pkt(2'd1, 2'd1, 6'd3);
    tick(); tick(); tick();
    chk("b3_busy_last", busy, 1);
    tick();
    chk("b3_busy_done", busy, 0);
    chk("b3_queue", exp_q.size(), 0);

    // Back-pressure on body flit 2
    push_word(14'hA); push_word(14'hB); push_word(14'hC);
    exp_q.push_back(head_of(2'd2, 2'd3, 6'd3));
    exp_q.push_back(body_of(1'b0, 14'hA));
    exp_q.push_back(body_of(1'b0, 14'hB));
    exp_q.push_back(body_of(1'b1, 14'hC));
    start_pkt(2'd2, 2'd3, 6'd3);
    tick(); tick();
    hand_shake = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_send", send, 1);
      chk("bp_flit", flit, body_of(1'b0, 14'hB));
    end
    hand_shake = 1'b1;
    tick(); tick();
    chk("bp_busy_done", busy, 0);

    // Starvation: body waits for payload
    exp_q.push_back(head_of(2'd0, 2'd1, 6'd2));
    exp_q.push_back(body_of(1'b0, 14'h111));
    exp_q.push_back(body_of(1'b1, 14'h222));
    start_pkt(2'd0, 2'd1, 6'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_send", send, 0);
      chk("st_busy", busy, 1);
    end
    push_word(14'h111);
    chk("st_resume_send", send, 1);
    wr_en = 1'b1; wr_data = 14'h222;
    tick();
    wr_en = 1'b0;
    chk("st_tail_flit", flit, body_of(1'b1, 14'h222));
    tick();
    chk("st_busy_done", busy, 0);

    // Fill to full, then a dropped write
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("fill_not_full", fifo_full, 0);
      push_word(14'h100 + 14'(i));
    end
    chk("fill_full", fifo_full, 1);
    push_word(14'h3FFF);
    chk("drop_full", fifo_full, 1);
    exp_q.push_back(head_of(2'd1, 2'd0, 6'd8));
    for (int i = 0; i < 8; i++) exp_q.push_back(body_of(i == 7, 14'h100 + 14'(i)));
    start_pkt(2'd1, 2'd0, 6'd8);
    for (int i = 0; i < 9; i++) tick();
    chk("drain_busy", busy, 0);
    chk("drain_full", fifo_full, 0);

    // turnoff during body
    push_word(14'h21); push_word(14'h22);
    exp_q.push_back(head_of(2'd3, 2'd3, 6'd2));
    exp_q.push_back(body_of(1'b0, 14'h21));
    exp_q.push_back(body_of(1'b1, 14'h22));
    start_pkt(2'd3, 2'd3, 6'd2);
    tick();
    turnoff = 1'b1;
    tick(); tick();
    chk("to_busy_done", busy, 0);
    chk("to_ready", pkt_ready, 0);
    pkt_start = 1'b1; pkt_dst_x = 2'd1; pkt_dst_y = 2'd1; pkt_len = 6'd0;
    tick();
    chk("to_ignored1", busy, 0);
    tick();
    chk("to_ignored2", busy, 0);
    pkt_start = 1'b0;
    turnoff = 1'b0;
    #1;
    chk("to_ready_back", pkt_ready, 1);

    // Reset mid-body
    push_word(14'h31); push_word(14'h32); push_word(14'h33);
    exp_q.push_back(head_of(2'd1, 2'd2, 6'd3));
    exp_q.push_back(body_of(1'b0, 14'h31));
    start_pkt(2'd1, 2'd2, 6'd3);
    tick(); tick();
    hand_shake = 1'b0;
    chk("mr_pre_send", send, 1);
    chk("mr_pre_flit", flit, body_of(1'b0, 14'h32));
    #2;
    reset = 1'b1;
    #1;
    chk("mr_send", send, 0);
    chk("mr_busy", busy, 0);
    chk("mr_flit", flit, 0);
    chk("mr_full", fifo_full, 0);
`ifdef NOC_INJ_STATS_EN
    chk("mr_flit_count", flit_count, 0);
    chk("mr_pkt_count", pkt_count, 0);
`endif
    tick();
    reset = 1'b0;
    tick();
    chk("mr_ready", pkt_ready, 1);
    hand_shake = 1'b1;
    exp_q.push_back(head_of(2'd0, 2'd0, 6'd1));
    start_pkt(2'd0, 2'd0, 6'd1);
    tick();
    chk("mr_fifo_empty_send", send, 0);
    chk("mr_fifo_empty_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
